bin_pixel_packer: RTL and testbench

- Sits between RAW2RGB and the SDRAM write-side FIFO (WR1) on the CCD pixel clock.
- Thresholds each valid 12-bit camera pixel to 1 bit and packs 16 consecutive pixels into one 16-bit word.
- Frames the stream with word addresses and a frame-done pulse, and buffers completed words in a 2-entry output queue with valid/ready handshaking.
- Replaces the free-running shift register and divided write clock: the SDRAM port receives exactly one write per packed word.

---
 rtl/bin_pack_pkg.sv | 24 ++
 rtl/pack_fifo2.sv | 53 +++++
 rtl/bin_pixel_packer.sv | 131 +++++++++++++
 tb/tb_bin_pixel_packer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_pack_pkg.sv
// Shared types and constants for the binary pixel packer.
package bin_pack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int PIX_W  = 12;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam int POP_W  = 19;

    localparam int LINE_PIX_DEF    = 640;
    localparam int LINE_CNT_DEF    = 480;
    localparam int WORDS_PER_FRAME = LINE_PIX_DEF * LINE_CNT_DEF / 16;

    // Foreground when the top 8 bits are strictly above the threshold.
    function automatic logic binarise(input logic [PIX_W-1:0] pix, input logic [7:0] thresh);
        return pix[11:4] > thresh;
    endfunction

endpackage

// File: rtl/pack_fifo2.sv
// Two-entry FIFO for {addr, data} words; push and pop in one cycle are both taken.
module pack_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         pop_ok;
    logic         push_ok;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i && !empty_o;
    // A simultaneous pop frees the slot, so a full queue can still take a push.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/bin_pixel_packer.sv
// Thresholds pixels to 1 bit, packs 16 per word with frame addressing.
// Define BIN_POPCOUNT_EN to build the per-frame foreground pixel counter.
module bin_pixel_packer
    import bin_pack_pkg::*;
#(
    parameter int LINE_PIX = LINE_PIX_DEF,
    parameter int LINE_CNT = LINE_CNT_DEF,
    parameter int WORD_W   = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEN,
    input  logic              iFRAME_START,
    input  logic [PIX_W-1:0]  iDATA,
    input  logic              iDVAL,
    input  logic [7:0]        iTHRESH,
    output logic [WORD_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oWORD_ADDR,
    output logic              oDVAL,
    input  logic              iREADY,
    output logic              oFRAME_DONE,
    output logic              oBUSY,
    output logic              oOVERFLOW,
    output logic              oSYNC_ERR,
    output logic [POP_W-1:0]  oPOP_CNT
);

    localparam int          WPF       = LINE_PIX * LINE_CNT / 16;
    localparam logic [15:0] LAST_ADDR = 16'(WPF - 1);
    localparam int          QW        = ADDR_W + WORD_W;

    state_e              state_q;
    logic [3:0]          bit_cnt_q;
    logic [WORD_W-1:0]   shift_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                ovf_q, serr_q, done_q;

    logic                start_frame, take_pix, pix_bit, word_done;
    logic [3:0]          cnt_base;
    logic [WORD_W-1:0]   shift_base, full_word;
    logic [ADDR_W-1:0]   addr_base;
    logic                q_full, q_empty, q_pop, q_drop;
    logic [QW-1:0]       q_dout;

    // A start pulse (from IDLE, or mid-frame) restarts packing and counts as pixel 0.
    always_comb begin
        start_frame = iFRAME_START && ((state_q == IDLE && iEN) || state_q == ACTIVE);
        take_pix    = iDVAL && (state_q == ACTIVE || start_frame);
        pix_bit     = binarise(iDATA, iTHRESH);
        cnt_base    = start_frame ? 4'd0 : bit_cnt_q;
        shift_base  = start_frame ? '0 : shift_q;
        addr_base   = start_frame ? '0 : addr_q;
        full_word   = shift_base | (WORD_W'(pix_bit) << cnt_base);
        word_done   = take_pix && (cnt_base == 4'd15);
    end

    assign q_pop  = !q_empty && iREADY;
    assign q_drop = word_done && q_full && !q_pop;

    pack_fifo2 #(.W(QW)) u_fifo (
        .clk_i   (iCLK),
        .rst_i   (iRST),
        .flush_i (1'b0),
        .push_i  (word_done),
        .data_i  ({addr_base, full_word}),
        .pop_i   (q_pop),
        .data_o  (q_dout),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
            serr_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_frame) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (iFRAME_START) serr_q <= 1'b1;
                    if (word_done && addr_base == LAST_ADDR) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            bit_cnt_q <= take_pix ? cnt_base + 4'd1 : cnt_base;
            shift_q   <= word_done ? '0 : (take_pix ? full_word : shift_base);
            addr_q    <= word_done ? addr_base + 16'd1 : addr_base;
            if (q_drop) ovf_q <= 1'b1;
        end
    end

`ifdef BIN_POPCOUNT_EN
    logic [POP_W-1:0] acc_q, pop_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            acc_q <= '0;
            pop_q <= '0;
        end else begin
            if (start_frame)   acc_q <= take_pix ? POP_W'(pix_bit) : '0;
            else if (take_pix) acc_q <= acc_q + POP_W'(pix_bit);
            if (state_q == DONE) pop_q <= acc_q;
        end
    end

    assign oPOP_CNT = pop_q;
`else
    assign oPOP_CNT = '0;
`endif

    assign oDATA       = q_dout[WORD_W-1:0];
    assign oWORD_ADDR  = q_dout[QW-1:WORD_W];
    assign oDVAL       = !q_empty;
    assign oFRAME_DONE = done_q;
    assign oBUSY       = (state_q != IDLE);
    assign oOVERFLOW   = ovf_q;
    assign oSYNC_ERR   = serr_q;

endmodule

// File: tb/tb_bin_pixel_packer.sv
// Directed and randomized bench for bin_pixel_packer against a queue-based reference model.
module tb_bin_pixel_packer;

    localparam int LP  = 32;
    localparam int LC  = 4;
    localparam int WPF = LP * LC / 16;

    logic        iCLK = 1'b0;
    logic        iRST, iEN, iFRAME_START, iDVAL, iREADY;
    logic [11:0] iDATA;
    logic [7:0]  iTHRESH;
    logic [15:0] oDATA, oWORD_ADDR;
    logic        oDVAL, oFRAME_DONE, oBUSY, oOVERFLOW, oSYNC_ERR;
    logic [18:0] oPOP_CNT;

    bin_pixel_packer #(.LINE_PIX(LP), .LINE_CNT(LC), .WORD_W(16)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iEN          (iEN),
        .iFRAME_START (iFRAME_START),
        .iDATA        (iDATA),
        .iDVAL        (iDVAL),
        .iTHRESH      (iTHRESH),
        .oDATA        (oDATA),
        .oWORD_ADDR   (oWORD_ADDR),
        .oDVAL        (oDVAL),
        .iREADY       (iREADY),
        .oFRAME_DONE  (oFRAME_DONE),
        .oBUSY        (oBUSY),
        .oOVERFLOW    (oOVERFLOW),
        .oSYNC_ERR    (oSYNC_ERR),
        .oPOP_CNT     (oPOP_CNT)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 1;   // 0: hold off, 1: always ready, 2: random
    int done_cnt = 0;

    // Reference model: mode 0 idle, 1 active, 2 done.
    int          m_mode;
    int          m_bits[$];
    int          m_addr;
    logic [31:0] exp_q[$];
    bit          m_ovf, m_serr;
    int          m_acc, m_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_bits.delete();
        m_addr = 0;
        exp_q.delete();
        m_ovf  = 0;
        m_serr = 0;
        m_acc  = 0;
        m_pop  = 0;
    endtask

    task automatic model_step(input bit start, input bit en, input bit dval,
                              input logic [11:0] data, input logic [7:0] th, input bit rdy);
        bit          popping, new_frame, take, have_w, b;
        int          prev_mode;
        logic [31:0] w;
        popping   = (exp_q.size() > 0) && rdy;
        prev_mode = m_mode;
        new_frame = 0;
        have_w    = 0;
        w         = '0;
        if (m_mode == 0 && start && en) begin
            new_frame = 1;
            m_mode    = 1;
        end else if (m_mode == 1 && start) begin
            new_frame = 1;
            m_serr    = 1;
        end else if (m_mode == 2) begin
            m_mode = 0;
            m_pop  = m_acc;
        end
        if (new_frame) begin
            m_bits.delete();
            m_addr = 0;
            m_acc  = 0;
        end
        take = dval && (prev_mode == 1 || new_frame);
        if (take) begin
            b = (data[11:4] > th);
            m_acc += int'(b);
            m_bits.push_back(int'(b));
            if (m_bits.size() == 16) begin
                for (int i = 0; i < 16; i++) w[i] = m_bits[i][0];
                w[31:16] = 16'(m_addr);
                have_w   = 1;
                if (m_addr == WPF - 1) m_mode = 2;
                m_addr++;
                m_bits.delete();
            end
        end
        if (popping) void'(exp_q.pop_front());
        if (have_w) begin
            if (exp_q.size() < 2) exp_q.push_back(w);
            else m_ovf = 1;
        end
    endtask

    task automatic check_outputs();
        chk("dval", {31'b0, oDVAL}, {31'b0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            chk("data", {16'b0, oDATA}, {16'b0, exp_q[0][15:0]});
            chk("addr", {16'b0, oWORD_ADDR}, {16'b0, exp_q[0][31:16]});
        end
        chk("frame_done", {31'b0, oFRAME_DONE}, {31'b0, m_mode == 2});
        chk("busy", {31'b0, oBUSY}, {31'b0, m_mode != 0});
        chk("overflow", {31'b0, oOVERFLOW}, {31'b0, m_ovf});
        chk("sync_err", {31'b0, oSYNC_ERR}, {31'b0, m_serr});
`ifdef BIN_POPCOUNT_EN
        chk("pop_cnt", {13'b0, oPOP_CNT}, 32'(m_pop));
`else
        chk("pop_cnt", {13'b0, oPOP_CNT}, 32'd0);
`endif
    endtask

    task automatic step(input bit start, input bit dval, input logic [11:0] data, input logic [7:0] th);
        iFRAME_START = start;
        iDVAL        = dval;
        iDATA        = data;
        iTHRESH      = th;
        iREADY       = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        @(posedge iCLK);
        model_step(start, iEN, dval, data, th, iREADY);
        #1;
        check_outputs();
        if (oFRAME_DONE) done_cnt++;
    endtask

    task automatic pix(input logic [11:0] d, input logic [7:0] th, input bit start, input int gap);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 12'($urandom), th);
        step(start, 1'b1, d, th);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (m_mode != 0 && n < 2000) begin
            step(1'b0, 1'b1, 12'($urandom), 8'($urandom));
            n++;
        end
        if (m_mode != 0) chk("frame_timeout", 32'd1, 32'd0);
        repeat (3) step(1'b0, 1'b0, 12'h0, 8'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        iRST = 1'b1; iEN = 1'b0; iFRAME_START = 1'b0; iDVAL = 1'b0;
        iDATA = '0; iTHRESH = '0; iREADY = 1'b0;
        model_reset();
        repeat (3) @(posedge iCLK);
        #1;
        check_outputs();
        chk("rst_data", {16'b0, oDATA}, 32'd0);
        chk("rst_addr", {16'b0, oWORD_ADDR}, 32'd0);
        iRST = 1'b0;

        // Alternating bright/dark pixels give 0x5555, visible the cycle after pixel 15.
        iEN = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) pix((i % 2 == 0) ? 12'hFF0 : 12'h000, 8'h80, i == 0, 0);
        chk("t1_dval", {31'b0, oDVAL}, 32'd1);
        chk("t1_data", {16'b0, oDATA}, 32'h5555);
        chk("t1_addr", {16'b0, oWORD_ADDR}, 32'd0);
        iEN = 1'b0;
        rdy_mode = 2;
        finish_frame();

        // Full frame of saturated pixels.
        iEN = 1'b1;
        rdy_mode = 1;
        d0 = done_cnt;
        for (int i = 0; i < LP * LC; i++) pix(12'hFFF, 8'h80, i == 0, 0);
        finish_frame();
        chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
`ifdef BIN_POPCOUNT_EN
        chk("t2_pop", {13'b0, oPOP_CNT}, 32'(LP * LC));
`endif

        // Stalled sink: third word dropped, next word carries addr 3.
        rdy_mode = 0;
        for (int i = 0; i < 48; i++) pix(12'($urandom), 8'($urandom), i == 0, 0);
        chk("t3_ovf", {31'b0, oOVERFLOW}, 32'd1);
        chk("t3_head_addr", {16'b0, oWORD_ADDR}, 32'd0);
        rdy_mode = 1;
        step(1'b0, 1'b0, 12'h0, 8'h0);
        chk("t3_second_addr", {16'b0, oWORD_ADDR}, 32'd1);
        for (int i = 0; i < 16; i++) pix(12'($urandom), 8'($urandom), 1'b0, 0);
        chk("t3_next_addr", {16'b0, oWORD_ADDR}, 32'd3);
        rdy_mode = 2;
        finish_frame();

        // Restart after 20 pixels.
        for (int i = 0; i < 20; i++) pix(12'($urandom), 8'($urandom), i == 0, 0);
        pix(12'($urandom), 8'($urandom), 1'b1, 0);
        chk("t4_sync_err", {31'b0, oSYNC_ERR}, 32'd1);
        finish_frame();

        // Pixels equal to the threshold are background; gapped stream afterwards.
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) pix({8'h80, 4'($urandom)}, 8'h80, i == 0, 0);
        chk("t5_eq_word", {16'b0, oDATA}, 32'h0000);
        for (int i = 0; i < 16; i++) pix({8'h81, 4'($urandom)}, 8'h80, 1'b0, 0);
        chk("t5_gt_word", {16'b0, oDATA}, 32'hFFFF);
        rdy_mode = 2;
        for (int i = 0; i < LP * LC - 32; i++)
            pix(12'($urandom), 8'($urandom), 1'b0, int'($urandom_range(1, 5)));
        finish_frame();

        // Reset with one word queued and 7 bits packed.
        rdy_mode = 0;
        for (int i = 0; i < 23; i++) pix(12'($urandom), 8'($urandom), i == 0, 0);
        chk("t6_pre_dval", {31'b0, oDVAL}, 32'd1);
        iRST = 1'b1;
        #1;
        model_reset();
        chk("t6_rst_dval", {31'b0, oDVAL}, 32'd0);
        chk("t6_rst_busy", {31'b0, oBUSY}, 32'd0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        rdy_mode = 2;
        for (int i = 0; i < LP * LC; i++) pix(12'($urandom), 8'($urandom), i == 0, 0);
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
